// File: rtl/pwm_tx_pkg.sv
// Shared types and timing defaults for the pulse-width frame transmitter.
// Serialiser states plus the helper that sizes the phase counter.
package pwm_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        BITS,
        PAR
    } tx_state_t;

    localparam int DEF_SYNC_LOW  = 400;
    localparam int DEF_SYNC_HIGH = 600;
    localparam int DEF_BIT_LOW   = 200;
    localparam int DEF_ZERO_HIGH = 200;
    localparam int DEF_ONE_HIGH  = 600;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pwm_frame_tx_if.sv
// Sample-side handshake between the audio source and the transmitter.
// The source strobes data_valid; drop reports a discarded sample.
interface pwm_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  data_ready;
    logic                  drop;

    modport master (
        output data,
        output data_valid,
        input  data_ready,
        input  drop
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready,
        output drop
    );
endinterface

// File: rtl/pwm_frame_tx_fifo.sv
// Small synchronous sample FIFO with registered occupancy.
// Pushes while full and pops while empty are ignored.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/pwm_frame_tx.sv
// Pulse-width frame transmitter: FIFO-buffered samples serialised as
// a sync pulse, one symbol per bit and an optional even-parity symbol.
module pwm_frame_tx
    import pwm_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SYNC_LOW   = DEF_SYNC_LOW,
    parameter int SYNC_HIGH  = DEF_SYNC_HIGH,
    parameter int BIT_LOW    = DEF_BIT_LOW,
    parameter int ZERO_HIGH  = DEF_ZERO_HIGH,
    parameter int ONE_HIGH   = DEF_ONE_HIGH,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY_EN  = 0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    pwm_frame_tx_if.slave  s,
    output logic           valid_out,
    output logic           out
);
    localparam int CW  = $clog2(max3(SYNC_LOW + SYNC_HIGH,
                                     BIT_LOW + ONE_HIGH,
                                     BIT_LOW + ZERO_HIGH) + 1);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LOW + SYNC_HIGH - 1);
    localparam logic [CW-1:0] SYNC_RISE = CW'(SYNC_LOW);
    localparam logic [CW-1:0] BIT_RISE  = CW'(BIT_LOW);
    localparam logic [CW-1:0] ZERO_LAST = CW'(BIT_LOW + ZERO_HIGH - 1);
    localparam logic [CW-1:0] ONE_LAST  = CW'(BIT_LOW + ONE_HIGH - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [FAW:0]  FIFO_FULL = (FAW+1)'(FIFO_DEPTH);

    tx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] head;
    logic [FAW:0]          fifo_count;
    logic                  parity;
    logic                  full;
    logic                  empty;
    logic                  drop_q;
    logic                  cur_bit;
    logic                  sym_end;
    logic                  sync_end;
    logic                  last_data;
    logic                  frame_end;
    logic                  fifo_pop;

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (s.data_valid),
        .din    (s.data),
        .pop    (fifo_pop),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    assign s.data_ready = ~full;
    assign s.drop       = drop_q;

    assign cur_bit   = (state == PAR) ? parity :
                       (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
    assign cnt_inc   = cnt + 1'b1;
    assign sym_end   = (cnt == (cur_bit ? ONE_LAST : ZERO_LAST));
    assign sync_end  = (cnt == SYNC_LAST);
    assign last_data = (bit_idx == LAST_BIT);
    assign frame_end = sym_end &&
                       ((state == PAR) ||
                        (state == BITS && last_data && PARITY_EN == 0));
    // Popping on the final cycle of a frame keeps valid_out gap-free.
    assign fifo_pop  = ~empty && ((state == IDLE) || frame_end);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            out       <= 1'b0;
            valid_out <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= s.data_valid & (fifo_count == FIFO_FULL);
            if (fifo_pop) begin
                state     <= SYNC;
                cnt       <= '0;
                bit_idx   <= '0;
                shreg     <= head;
                parity    <= ^head;
                out       <= 1'b0;
                valid_out <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        out       <= 1'b0;
                        valid_out <= 1'b0;
                    end
                    SYNC: begin
                        if (sync_end) begin
                            state <= BITS;
                            cnt   <= '0;
                            out   <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                            out <= (cnt_inc >= SYNC_RISE);
                        end
                    end
                    BITS: begin
                        if (sym_end) begin
                            cnt     <= '0;
                            out     <= 1'b0;
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= (MSB_FIRST != 0) ? (shreg << 1)
                                                        : (shreg >> 1);
                            if (last_data) begin
                                state     <= (PARITY_EN != 0) ? PAR : IDLE;
                                valid_out <= (PARITY_EN != 0);
                            end
                        end else begin
                            cnt <= cnt_inc;
                            out <= (cnt_inc >= BIT_RISE);
                        end
                    end
                    PAR: begin
                        if (sym_end) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            out       <= 1'b0;
                            valid_out <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                            out <= (cnt_inc >= BIT_RISE);
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_frame_tx.sv
// Directed bench for pwm_frame_tx: three parameterisations, frame
// timing decoded from the line and compared with a symbol model.
module tb_pwm_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic va, oa, vb, ob, vc, oc;

    int checks   = 0;
    int failures = 0;
    int hw[$];
    int eq[$];
    int flen;
    int elen;

    pwm_frame_tx_if #(.DATA_WIDTH(8))  ia ();
    pwm_frame_tx_if #(.DATA_WIDTH(8))  ib ();
    pwm_frame_tx_if #(.DATA_WIDTH(12)) ic ();

    pwm_frame_tx dut_a (
        .clk_in    (clk),
        .rst_in    (rst),
        .s         (ia),
        .valid_out (va),
        .out       (oa)
    );

    pwm_frame_tx #(.MSB_FIRST(0), .PARITY_EN(1)) dut_b (
        .clk_in    (clk),
        .rst_in    (rst),
        .s         (ib),
        .valid_out (vb),
        .out       (ob)
    );

    pwm_frame_tx #(.DATA_WIDTH(12)) dut_c (
        .clk_in    (clk),
        .rst_in    (rst),
        .s         (ic),
        .valid_out (vc),
        .out       (oc)
    );

    initial forever #5 clk = ~clk;

    function automatic logic get_v(input int d);
        case (d)
            0:       return va;
            1:       return vb;
            default: return vc;
        endcase
    endfunction

    function automatic logic get_o(input int d);
        case (d)
            0:       return oa;
            1:       return ob;
            default: return oc;
        endcase
    endfunction

    function automatic logic get_r(input int d);
        case (d)
            0:       return ia.data_ready;
            1:       return ib.data_ready;
            default: return ic.data_ready;
        endcase
    endfunction

    task automatic set_in(input int d, input logic [31:0] x, input logic v);
        case (d)
            0: begin ia.data = x[7:0];  ia.data_valid = v; end
            1: begin ib.data = x[7:0];  ib.data_valid = v; end
            default: begin ic.data = x[11:0]; ic.data_valid = v; end
        endcase
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input logic [31:0] x, input int w,
                             input bit msb, input bit par);
        bit b;
        bit p;
        p = 1'b0;
        eq.push_back(600);
        elen += 1000;
        for (int i = 0; i < w; i++) begin
            b = msb ? x[w-1-i] : x[i];
            p ^= b;
            eq.push_back(b ? 600 : 200);
            elen += b ? 800 : 400;
        end
        if (par) begin
            eq.push_back(p ? 600 : 200);
            elen += p ? 800 : 400;
        end
    endtask

    // Accept on this cycle; expects first SYNC cycle two cycles later.
    task automatic start(input int d, input logic [31:0] x, input string tag);
        chk({tag, "_ready"}, int'(get_r(d)), 1);
        set_in(d, x, 1'b1);
        @(negedge clk);
        set_in(d, x, 1'b0);
        chk({tag, "_lat1_valid"}, int'(get_v(d)), 0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, int'(get_v(d)), 1);
        chk({tag, "_lat2_out"}, int'(get_o(d)), 0);
    endtask

    task automatic measure(input int d, input int tmo, input int pre,
                           input string tag);
        int run;
        int n;
        hw.delete();
        flen = pre;
        run  = 0;
        n    = 0;
        while (!get_v(d) && n < tmo) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, int'(get_v(d)), 1);
        while (get_v(d) && flen < 60000) begin
            if (get_o(d)) run++;
            else if (run > 0) begin
                hw.push_back(run);
                run = 0;
            end
            flen++;
            @(negedge clk);
        end
        if (run > 0) hw.push_back(run);
        chk({tag, "_out_after"}, int'(get_o(d)), 0);
    endtask

    task automatic cmp_frame(input string tag);
        int n;
        chk({tag, "_len"}, flen, elen);
        chk({tag, "_nsym"}, hw.size(), eq.size());
        n = (hw.size() < eq.size()) ? hw.size() : eq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_high%0d", tag, i), hw[i], eq[i]);
    endtask

    initial begin
        int el;
        int hits;
        logic [7:0] burst [5];
        burst[0] = 8'h0F;
        burst[1] = 8'hF0;
        burst[2] = 8'h00;
        burst[3] = 8'h81;
        burst[4] = 8'hFF;

        set_in(0, 0, 1'b0);
        set_in(1, 0, 1'b0);
        set_in(2, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_valid_a", int'(va), 0);
        chk("rst_out_a", int'(oa), 0);
        chk("rst_drop_a", int'(ia.drop), 0);
        chk("rst_valid_b", int'(vb), 0);
        chk("rst_valid_c", int'(vc), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_a", int'(ia.data_ready), 1);
        chk("rst_ready_c", int'(ic.data_ready), 1);

        // Defaults, single 0xA5.
        eq.delete(); elen = 0;
        add_frame(32'hA5, 8, 1'b1, 1'b0);
        start(0, 32'hA5, "a5");
        measure(0, 10, 0, "a5");
        cmp_frame("a5");
        chk("a5_total", flen, 5800);

        // LSB first with parity.
        eq.delete(); elen = 0;
        add_frame(32'h01, 8, 1'b0, 1'b1);
        start(1, 32'h01, "par");
        measure(1, 10, 0, "par");
        cmp_frame("par");
        chk("par_total", flen, 5400);

        // Busy line, five consecutive strobes, fifth dropped.
        eq.delete(); elen = 0;
        add_frame(32'h00, 8, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            add_frame(32'(burst[i]), 8, 1'b1, 1'b0);
        start(0, 32'h00, "busy");
        el = 0;
        repeat (10) begin
            @(negedge clk);
            el++;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("burst_ready%0d", i), int'(ia.data_ready),
                (i < 4) ? 1 : 0);
            set_in(0, 32'(burst[i]), 1'b1);
            @(negedge clk);
            el++;
        end
        set_in(0, 0, 1'b0);
        chk("burst_drop_hi", int'(ia.drop), 1);
        @(negedge clk);
        el++;
        chk("burst_drop_lo", int'(ia.drop), 0);
        chk("burst_ready_full", int'(ia.data_ready), 0);
        measure(0, 10, el, "burst");
        cmp_frame("burst");
        chk("burst_total", flen, 25000);

        // Twelve-bit sample, all ones.
        eq.delete(); elen = 0;
        add_frame(32'hFFF, 12, 1'b1, 1'b0);
        start(2, 32'hFFF, "w12");
        measure(2, 10, 0, "w12");
        cmp_frame("w12");
        chk("w12_total", flen, 10600);

        // Asynchronous reset in the middle of the data symbols.
        start(0, 32'hA5, "mid");
        set_in(0, 32'h3C, 1'b1);
        @(negedge clk);
        set_in(0, 0, 1'b0);
        repeat (2000) @(negedge clk);
        chk("mid_busy", int'(va), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(va), 0);
        chk("mid_rst_out", int'(oa), 0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (va) hits++;
        end
        chk("mid_no_residual", hits, 0);
        eq.delete(); elen = 0;
        add_frame(32'h00, 8, 1'b1, 1'b0);
        start(0, 32'h00, "post");
        measure(0, 10, 0, "post");
        cmp_frame("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
